result_drain: RTL and testbench
===============================

# result_drain

Downstream stage of the 4x4 systolic core. On a start pulse it snapshots the core's sixteen ACCUMULATE-bit result-buffer entries. It then requantizes each entry to a WIDTH-bit signed value, using a rounding arithmetic right shift followed by saturation. The 16 values are streamed out one per handshake over a valid/ready port toward the activation/writeback path, and the core is free to start the next tile immediately after the snapshot.

## Interface
- ACCUMULATE, 32, width of each signed accumulator entry
- WIDTH, 16, width of each signed output element
- NUM_RESULTS, 16, number of entries drained per tile (fixed 4x4)

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; all state cleared while low
- start  input  1  one-cycle pulse: capture result_buffer and shift, begin drain
- result_buffer  input  NUM_RESULTS*ACCUMULATE  core results; entry i = bits [i*ACCUMULATE +: ACCUMULATE], signed
- shift  input  5  right-shift amount (0..31), sampled only with start
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  consumer accepts element when high with out_valid
- out_data  output  WIDTH  requantized signed element
- out_index  output  4  index i of the element on out_data
- out_last  output  1  high with out_valid for index 15
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse after final handshake

## Operation
- FSM states: IDLE, DRAIN.
- IDLE:
  - start=1 loads all 16 entries into a local snapshot register file, latches shift, and sets idx=0.
  - Next state DRAIN.
- DRAIN:
  - out_valid=1; out_data = requant(snapshot[idx]); out_index=idx; out_last=(idx==15).
  - On out_valid&out_ready, idx increments.
  - Handshake at idx==15 -> IDLE; done=1 for the following cycle.
- start during DRAIN is ignored. The snapshot and shift do not change mid-drain.
- requant(x), for signed ACCUMULATE-bit x and shift s:
  - Work in ACCUMULATE+1 bits so the rounding add cannot wrap.
  - If s>0, add 1<<(s-1) (round half up), then arithmetic shift right by s. If s==0, pass x through.
  - Saturate to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1].
- out_data, out_index and out_last are registered. They stay stable while out_valid&!out_ready.
- Holding out_valid high without out_ready is legal indefinitely; no element is dropped or duplicated.

## Timing
- Reset values: out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0; FSM=IDLE; snapshot cleared.
- Start accepted in cycle t: out_valid and busy go high in cycle t+1 with element 0.
- With out_ready held high, elements 0..15 appear in cycles t+1..t+16 and done pulses in cycle t+17.
- Throughput is one element per cycle; each cycle with out_ready low adds exactly one cycle.
- busy falls in the same cycle done rises.
- done and start in the same cycle: start is accepted, done still pulses, and the next drain begins the following cycle (back-to-back tiles, no bubble beyond one cycle).
- Reset asserted mid-drain: outputs return to reset values immediately (asynchronously). After reset releases, the block is in IDLE with no residual done pulse.

## Structure
- Shared package nnoc_pkg:
  - state enum {IDLE, DRAIN}
  - NUM_RESULTS=16
  - default ACCUMULATE/WIDTH constants
- Sub-module requant_sat: purely combinational, parameterized by ACCUMULATE and WIDTH, with inputs x and shift and output y. The top level holds the FSM, index counter, snapshot registers and output registers.

## Test plan
- Basic drain: entries i = 100*i, shift=2, out_ready=1 -> out_data sequence 0,25,50,...,375 in cycles t+1..t+16; out_last only at index 15; done at t+17.
- Rounding and sign: entry0=-5, entry1=6, entry2=7, shift=1 -> -2, 3, 4.
- Saturation: entry0=32'h7FFFFFFF, entry1=-40000, entry2=32'h80000000, shift=0 -> 32767, -32768, -32768. Also entry=32'h7FFFFFFF with shift=31 -> 1, with no wrap.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> all 16 elements appear exactly once, in order, and out_data is held stable while stalled. done is delayed by exactly the number of stall cycles.
- Snapshot isolation: after start, change result_buffer and shift and pulse start again mid-drain -> output still reflects the original snapshot and shift; the second start is ignored.
- Reset mid-drain: assert reset at index 7 -> out_valid/busy/done low at once; release and start a new tile -> element 0 of the new tile appears one cycle after start.

Source files
------------

// File: rtl/nnoc_pkg.sv
// Shared types and sizing for the systolic core's downstream stages.
package nnoc_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    localparam int NUM_RESULTS    = 16;
    localparam int DEF_ACCUMULATE = 32;
    localparam int DEF_WIDTH      = 16;
endpackage

// File: rtl/requant_sat.sv
// Rounding arithmetic right shift followed by signed saturation to WIDTH bits.
module requant_sat #(
    parameter int ACCUMULATE = 32,
    parameter int WIDTH      = 16
) (
    input  logic [ACCUMULATE-1:0] x,
    input  logic [4:0]            shift,
    output logic [WIDTH-1:0]      y
);
    localparam logic signed [ACCUMULATE:0] SMAX =
        {{(ACCUMULATE-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCUMULATE:0] SMIN =
        {{(ACCUMULATE-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [ACCUMULATE:0] xe;
    logic signed [ACCUMULATE:0] rnd;
    logic signed [ACCUMULATE:0] sum;
    logic signed [ACCUMULATE:0] shr;

    // One extra bit of headroom keeps the half-up rounding add from wrapping.
    always_comb begin
        xe  = {x[ACCUMULATE-1], x};
        rnd = '0;
        if (shift != 5'd0)
            rnd = (ACCUMULATE+1)'(1) << (shift - 5'd1);
        sum = xe + rnd;
        shr = sum >>> shift;
        if (shr > SMAX)
            y = SMAX[WIDTH-1:0];
        else if (shr < SMIN)
            y = SMIN[WIDTH-1:0];
        else
            y = shr[WIDTH-1:0];
    end
endmodule

// File: rtl/result_drain.sv
// Snapshots the 4x4 core result buffer on start and streams requantized
// elements out over valid/ready, one per handshake.
module result_drain
    import nnoc_pkg::*;
#(
    parameter int ACCUMULATE = DEF_ACCUMULATE,
    parameter int WIDTH      = DEF_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_RESULTS*ACCUMULATE-1:0] result_buffer,
    input  logic [4:0]                        shift,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [3:0]                        out_index,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);
    state_t                                   state;
    logic [NUM_RESULTS-1:0][ACCUMULATE-1:0]   snap;
    logic [4:0]                               shift_q;
    logic [3:0]                               idx;
    logic [3:0]                               idx_nxt;
    logic [ACCUMULATE-1:0]                    rq_x;
    logic [4:0]                               rq_s;
    logic [WIDTH-1:0]                         rq_y;

    assign idx_nxt = idx + 4'd1;

    // In IDLE the requantizer looks at the live buffer so element 0 is ready
    // the cycle after start; in DRAIN it prefetches the next snapshot entry.
    always_comb begin
        rq_x = result_buffer[ACCUMULATE-1:0];
        rq_s = shift;
        if (state == DRAIN) begin
            rq_x = snap[idx_nxt];
            rq_s = shift_q;
        end
    end

    requant_sat #(.ACCUMULATE(ACCUMULATE), .WIDTH(WIDTH)) u_requant (
        .x     (rq_x),
        .shift (rq_s),
        .y     (rq_y)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            snap      <= '0;
            shift_q   <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap      <= result_buffer;
                        shift_q   <= shift;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= rq_y;
                        out_index <= '0;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx == 4'd15) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx       <= idx_nxt;
                            out_data  <= rq_y;
                            out_index <= idx_nxt;
                            out_last  <= (idx_nxt == 4'd15);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_drain.sv
// Directed self-checking bench for result_drain.
module tb_result_drain;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [511:0]  result_buffer = '0;
    logic [4:0]    shift = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   out_data;
    logic [3:0]    out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] exp_d [16];

    always #5 clk = ~clk;

    result_drain dut (
        .clk(clk), .reset(reset), .start(start), .result_buffer(result_buffer),
        .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_entry(input int i, input logic [31:0] v);
        result_buffer[i*32 +: 32] = v;
    endtask

    // Pulse start across one rising edge; returns at the t+1 sample point.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drains 16 elements with out_ready high, ends at the done cycle.
    task automatic drain_all(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"},  32'(out_data),  32'(exp_d[k]));
            chk({tag, "_index"}, 32'(out_index), 32'(k));
            chk({tag, "_last"},  32'(out_last),  32'(k == 15));
            @(negedge clk);
        end
        chk({tag, "_done"},  32'(done),      32'd1);
        chk({tag, "_busy0"}, 32'(busy),      32'd0);
        chk({tag, "_vld0"},  32'(out_valid), 32'd0);
    endtask

    initial begin
        int k, cyc, stalls;
        logic [15:0] held;

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic drain: 100*i >> 2 with rounding -> 25*i
        for (int i = 0; i < 16; i++) begin
            set_entry(i, 32'(100 * i));
            exp_d[i] = 16'(25 * i);
        end
        shift = 5'd2;
        pulse_start();
        chk("basic_busy", 32'(busy), 32'd1);
        drain_all("basic");

        // Back-to-back: start in the done cycle; rounding and sign
        result_buffer = '0;
        set_entry(0, -32'sd5);
        set_entry(1, 32'd6);
        set_entry(2, 32'd7);
        shift = 5'd1;
        for (int i = 0; i < 16; i++) exp_d[i] = 16'd0;
        exp_d[0] = 16'hFFFE;
        exp_d[1] = 16'd3;
        exp_d[2] = 16'd4;
        pulse_start();
        chk("b2b_done_clr", 32'(done), 32'd0);
        chk("b2b_busy",     32'(busy), 32'd1);
        drain_all("round");

        // Saturation at shift 0
        result_buffer = '0;
        set_entry(0, 32'h7FFF_FFFF);
        set_entry(1, -32'sd40000);
        set_entry(2, 32'h8000_0000);
        shift = 5'd0;
        for (int i = 0; i < 16; i++) exp_d[i] = 16'd0;
        exp_d[0] = 16'h7FFF;
        exp_d[1] = 16'h8000;
        exp_d[2] = 16'h8000;
        @(negedge clk);
        pulse_start();
        drain_all("sat");

        // Max entry with shift 31 rounds to 1 without wrapping
        result_buffer = '0;
        set_entry(0, 32'h7FFF_FFFF);
        set_entry(1, 32'h8000_0000);
        shift = 5'd31;
        for (int i = 0; i < 16; i++) exp_d[i] = 16'd0;
        exp_d[0] = 16'd1;
        exp_d[1] = 16'hFFFF;
        @(negedge clk);
        pulse_start();
        drain_all("sh31");

        // Backpressure: ready pattern 1,0,0,1
        for (int i = 0; i < 16; i++) begin
            set_entry(i, 32'(100 * i));
            exp_d[i] = 16'(25 * i);
        end
        shift = 5'd2;
        @(negedge clk);
        pulse_start();
        k = 0; cyc = 0; stalls = 0;
        while (k < 16 && cyc < 200) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data",  32'(out_data),  32'(exp_d[k]));
            chk("bp_index", 32'(out_index), 32'(k));
            if (out_ready) k++;
            else stalls++;
            cyc++;
            @(negedge clk);
        end
        chk("bp_count", 32'(k), 32'd16);
        chk("bp_cycles", 32'(cyc), 32'(16 + stalls));
        chk("bp_done", 32'(done), 32'd1);
        out_ready = 1'b1;

        // Snapshot isolation: mutate inputs and re-pulse start mid-drain
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                result_buffer = {16{32'h0001_0000}};
                shift = 5'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk("iso_data",  32'(out_data),  32'(exp_d[i]));
            chk("iso_index", 32'(out_index), 32'(i));
            @(negedge clk);
        end
        start = 1'b0;
        chk("iso_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("iso_idle", 32'(out_valid), 32'd0);

        // Reset mid-drain at index 7, with a stall so outputs are held
        for (int i = 0; i < 16; i++) set_entry(i, 32'(100 * i));
        shift = 5'd2;
        pulse_start();
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("mid_index", 32'(out_index), 32'd7);
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        chk("stall_hold_idx", 32'(out_index), 32'd7);
        chk("stall_hold_data", 32'(held), 32'd175);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_done",  32'(done),      32'd0);
        chk("arst_data",  32'(out_data),  32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_valid", 32'(out_valid), 32'd0);
        result_buffer = '0;
        set_entry(0, -32'sd5);
        shift = 5'd1;
        pulse_start();
        chk("new_valid", 32'(out_valid), 32'd1);
        chk("new_data",  32'(out_data),  32'h0000_FFFE);
        chk("new_index", 32'(out_index), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
